// File: rtl/multi_channel_producer.sv
// Purpose : per-channel traffic generator (incrementing address, tagged sequence ID) plus per-channel flush pulses.
// Latency : all outputs registered; an input change is reflected one clk edge later.
// Backpressure: in_stall[i] freezes channel i (address, ID, valid, seq, gap); flushes ignore stall.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_stall, ch_enable     per-channel freeze / issue enable
//   flush_req(_ch/_id)      single-cycle external flush request, target channel and ID
//   out_address/out_id      packed per-channel request address / ID, with out_valid
//   flush/flush_id          packed per-channel one-cycle flush pulse and its ID
//   flush_busy              scheduled flush displaced by an external flush and waiting
module multi_channel_producer #(
   parameter int              NUM_CH      = 2,
   parameter int              ADDR_W      = 32,
   parameter int              ID_W        = 8,
   parameter int              SEQ_W       = 4,
   parameter int              STRIDE      = 4,
   parameter int              ISSUE_GAP   = 0,
   parameter int              FLUSH_DELAY = 44,
   parameter int              FLUSH_CH    = 0,
   parameter logic [ID_W-1:0] FLUSH_ID    = 8'h16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_CH-1:0]        in_stall,
   input  logic [NUM_CH-1:0]        ch_enable,
   input  logic                     flush_req,
   input  logic [2:0]               flush_req_ch,
   input  logic [ID_W-1:0]          flush_req_id,
   output logic [NUM_CH*ADDR_W-1:0] out_address,
   output logic [NUM_CH*ID_W-1:0]   out_id,
   output logic [NUM_CH-1:0]        out_valid,
   output logic [NUM_CH-1:0]        flush,
   output logic [NUM_CH*ID_W-1:0]   flush_id,
   output logic                     flush_busy
);

   localparam int TAG_W = ID_W - SEQ_W;
   localparam int GAP_W = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
   localparam int CNT_W = (FLUSH_DELAY > 0) ? $clog2(FLUSH_DELAY + 1) : 1;

   // per-channel issue state
   logic [ADDR_W-1:0] addr_q [NUM_CH];
   logic [ADDR_W-1:0] addr_d [NUM_CH];
   logic [ID_W-1:0]   id_q   [NUM_CH];
   logic [ID_W-1:0]   id_d   [NUM_CH];
   logic [SEQ_W-1:0]  seq_q  [NUM_CH];
   logic [SEQ_W-1:0]  seq_d  [NUM_CH];
   logic [GAP_W-1:0]  gap_q  [NUM_CH];
   logic [GAP_W-1:0]  gap_d  [NUM_CH];
   logic [NUM_CH-1:0] vld_q;
   logic [NUM_CH-1:0] vld_d;

   // flush state
   logic [NUM_CH-1:0] flush_q;
   logic [NUM_CH-1:0] flush_d;
   logic [ID_W-1:0]   flush_id_q [NUM_CH];
   logic [ID_W-1:0]   flush_id_d [NUM_CH];
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              issued_q;
   logic              issued_d;
   logic              busy_q;
   logic              busy_d;

   logic              ext_ok;
   logic              sched_due;
   logic              collide;

   // ---------------------------------------------------------------
   // Per-channel issue
   // ---------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         addr_d[i] = addr_q[i];
         id_d[i]   = id_q[i];
         seq_d[i]  = seq_q[i];
         gap_d[i]  = gap_q[i];
         vld_d[i]  = vld_q[i];
         if (!in_stall[i]) begin
            if (gap_q[i] != '0) begin
               vld_d[i] = 1'b0;
               gap_d[i] = gap_q[i] - GAP_W'(1);
            end else if (!ch_enable[i]) begin
               vld_d[i] = 1'b0;
            end else begin
               addr_d[i] = addr_q[i] + ADDR_W'(STRIDE);
               seq_d[i]  = seq_q[i] + SEQ_W'(1);
               // tag is the 1-based channel number so channel 0 never emits tag 0
               id_d[i]   = {TAG_W'(i + 1), seq_q[i] + SEQ_W'(1)};
               vld_d[i]  = 1'b1;
               gap_d[i]  = GAP_W'(ISSUE_GAP);
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // Flush generation: external request wins over the scheduled one
   // ---------------------------------------------------------------
   always_comb begin
      ext_ok    = flush_req && (32'(flush_req_ch) < NUM_CH);
      sched_due = (cnt_q == '0) && !issued_q;
      collide   = sched_due && ext_ok && (flush_req_ch == 3'(FLUSH_CH));

      cnt_d    = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
      issued_d = issued_q;
      busy_d   = 1'b0;
      flush_d  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         flush_id_d[i] = '0;
         if (ext_ok && (flush_req_ch == 3'(i))) begin
            flush_d[i]    = 1'b1;
            flush_id_d[i] = flush_req_id;
         end
      end

      if (sched_due) begin
         if (collide) begin
            // stay due; retry on the next edge
            busy_d = 1'b1;
         end else begin
            flush_d[FLUSH_CH]    = 1'b1;
            flush_id_d[FLUSH_CH] = FLUSH_ID;
            issued_d             = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            addr_q[i]     <= '0;
            id_q[i]       <= '0;
            seq_q[i]      <= '0;
            gap_q[i]      <= '0;
            flush_id_q[i] <= '0;
         end
         vld_q    <= '0;
         flush_q  <= '0;
         cnt_q    <= CNT_W'(FLUSH_DELAY);
         issued_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            addr_q[i]     <= addr_d[i];
            id_q[i]       <= id_d[i];
            seq_q[i]      <= seq_d[i];
            gap_q[i]      <= gap_d[i];
            flush_id_q[i] <= flush_id_d[i];
         end
         vld_q    <= vld_d;
         flush_q  <= flush_d;
         cnt_q    <= cnt_d;
         issued_q <= issued_d;
         busy_q   <= busy_d;
      end
   end

   // ---------------------------------------------------------------
   // Output packing
   // ---------------------------------------------------------------
   for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
      assign out_address[g*ADDR_W +: ADDR_W] = addr_q[g];
      assign out_id[g*ID_W +: ID_W]          = id_q[g];
      assign flush_id[g*ID_W +: ID_W]        = flush_id_q[g];
   end

   assign out_valid  = vld_q;
   assign flush      = flush_q;
   assign flush_busy = busy_q;

endmodule

// File: tb/tb_multi_channel_producer.sv
// Purpose : directed bench for multi_channel_producer (default instance plus a 5-bit-address, gap-2 instance).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpressure: in_stall driven directly by the stimulus.
module tb_multi_channel_producer;

   logic        clk;
   logic        reset_n;
   logic [1:0]  in_stall;
   logic [1:0]  ch_enable;
   logic        flush_req;
   logic [2:0]  flush_req_ch;
   logic [7:0]  flush_req_id;

   logic [63:0] out_address;
   logic [15:0] out_id;
   logic [1:0]  out_valid;
   logic [1:0]  flush;
   logic [15:0] flush_id;
   logic        flush_busy;

   logic [9:0]  g_address;
   logic [15:0] g_id;
   logic [1:0]  g_valid;
   logic [1:0]  g_flush;
   logic [15:0] g_flush_id;
   logic        g_flush_busy;

   int n_chk  = 0;
   int n_pass = 0;

   multi_channel_producer u_dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_stall     (in_stall),
      .ch_enable    (ch_enable),
      .flush_req    (flush_req),
      .flush_req_ch (flush_req_ch),
      .flush_req_id (flush_req_id),
      .out_address  (out_address),
      .out_id       (out_id),
      .out_valid    (out_valid),
      .flush        (flush),
      .flush_id     (flush_id),
      .flush_busy   (flush_busy)
   );

   multi_channel_producer #(.ADDR_W(5), .ISSUE_GAP(2)) u_gap (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_stall     (in_stall),
      .ch_enable    (ch_enable),
      .flush_req    (flush_req),
      .flush_req_ch (flush_req_ch),
      .flush_req_id (flush_req_id),
      .out_address  (g_address),
      .out_id       (g_id),
      .out_valid    (g_valid),
      .flush        (g_flush),
      .flush_id     (g_flush_id),
      .flush_busy   (g_flush_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // expected valid/address of u_gap ch0 after edges 1..12 (stall on edges 8,9)
   logic       gv [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   logic [4:0] ga [12] = '{5'd4, 5'd4, 5'd4, 5'd8, 5'd8, 5'd8, 5'd12, 5'd12, 5'd12, 5'd12, 5'd12, 5'd16};

   initial begin
      reset_n      = 1'b0;
      in_stall     = 2'b00;
      ch_enable    = 2'b00;
      flush_req    = 1'b0;
      flush_req_ch = 3'd0;
      flush_req_id = 8'h00;

      // ---------------- reset state ----------------
      #3;
      chk("rst_addr",  64'(out_address), 64'h0);
      chk("rst_id",    64'(out_id),      64'h0);
      chk("rst_valid", 64'(out_valid),   64'h0);
      chk("rst_flush", 64'(flush),       64'h0);
      chk("rst_busy",  64'(flush_busy),  64'h0);

      // ---------------- phase A: issue, stall, seq wrap ----------------
      #9;
      reset_n   = 1'b1;
      ch_enable = 2'b11;
      tick();
      chk("a1_addr0",  64'(out_address[31:0]),  64'd4);
      chk("a1_addr1",  64'(out_address[63:32]), 64'd4);
      chk("a1_id0",    64'(out_id[7:0]),        64'h11);
      chk("a1_id1",    64'(out_id[15:8]),       64'h21);
      chk("a1_valid",  64'(out_valid),          64'h3);
      tick();
      chk("a2_addr0",  64'(out_address[31:0]),  64'd8);
      chk("a2_id0",    64'(out_id[7:0]),        64'h12);
      chk("a2_id1",    64'(out_id[15:8]),       64'h22);

      in_stall = 2'b01;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stall_addr0", 64'(out_address[31:0]),  64'd8);
         chk("stall_id0",   64'(out_id[7:0]),        64'h12);
         chk("stall_vld0",  64'(out_valid[0]),       64'h1);
         chk("stall_addr1", 64'(out_address[63:32]), 64'(12 + 4*k));
         chk("stall_id1",   64'(out_id[15:8]),       64'(8'h23 + k));
      end
      in_stall = 2'b00;
      tick();
      chk("resume_addr0", 64'(out_address[31:0]),  64'd12);
      chk("resume_id0",   64'(out_id[7:0]),        64'h13);
      chk("resume_addr1", 64'(out_address[63:32]), 64'd24);
      chk("resume_id1",   64'(out_id[15:8]),       64'h26);

      for (int k = 4; k <= 16; k++) begin
         tick();
         chk("seq_addr0", 64'(out_address[31:0]), 64'(4*k));
         chk("seq_id0",   64'(out_id[7:0]),       64'(8'h10 | (k % 16)));
      end

      ch_enable = 2'b00;
      tick();
      chk("dis_valid", 64'(out_valid),         64'h0);
      chk("dis_addr0", 64'(out_address[31:0]), 64'd64);
      chk("dis_id0",   64'(out_id[7:0]),       64'h10);

      ch_enable = 2'b11;
      tick();
      chk("re_addr0",  64'(out_address[31:0]), 64'd68);
      chk("re_id0",    64'(out_id[7:0]),       64'h11);
      chk("re_valid",  64'(out_valid),         64'h3);

      // mid-stream asynchronous reset
      reset_n = 1'b0;
      #1;
      chk("arst_addr",  64'(out_address), 64'h0);
      chk("arst_id",    64'(out_id),      64'h0);
      chk("arst_valid", 64'(out_valid),   64'h0);
      chk("arst_gvld",  64'(g_valid),     64'h0);
      ch_enable = 2'b00;
      #1;
      reset_n = 1'b1;

      // ---------------- phase B: scheduled and external flush ----------------
      for (int e = 1; e <= 44; e++) begin
         tick();
         chk("sched_early", 64'(flush), 64'h0);
      end
      tick();
      chk("sched_flush", 64'(flush),      64'h1);
      chk("sched_id",    64'(flush_id),   64'h0016);
      chk("sched_busy",  64'(flush_busy), 64'h0);
      chk("idle_valid",  64'(out_valid),  64'h0);
      tick();
      chk("sched_end",    64'(flush),    64'h0);
      chk("sched_end_id", 64'(flush_id), 64'h0);
      for (int e = 0; e < 10; e++) begin
         tick();
         chk("sched_once", 64'(flush), 64'h0);
      end

      flush_req    = 1'b1;
      flush_req_ch = 3'd1;
      flush_req_id = 8'h2A;
      tick();
      chk("ext_flush", 64'(flush),    64'h2);
      chk("ext_id",    64'(flush_id), 64'h2A00);
      flush_req_ch = 3'd2;
      flush_req_id = 8'h33;
      tick();
      chk("ext_badch",    64'(flush),    64'h0);
      chk("ext_badch_id", 64'(flush_id), 64'h0);
      flush_req = 1'b0;
      tick();
      chk("ext_end", 64'(flush), 64'h0);

      // ---------------- phase C: issue gap, address wrap, collision ----------------
      reset_n = 1'b0;
      #2;
      reset_n   = 1'b1;
      ch_enable = 2'b11;
      for (int e = 1; e <= 24; e++) begin
         in_stall = (e == 8 || e == 9) ? 2'b01 : 2'b00;
         tick();
         if (e <= 12) begin
            chk("gap_valid", 64'(g_valid[0]),     64'(gv[e-1]));
            chk("gap_addr",  64'(g_address[4:0]), 64'(ga[e-1]));
         end
         if (e == 21) chk("wrap_pre",  64'(g_address[4:0]), 64'd28);
         if (e == 24) begin
            chk("wrap_addr",  64'(g_address[4:0]), 64'd0);
            chk("wrap_id",    64'(g_id[7:0]),      64'h18);
            chk("wrap_valid", 64'(g_valid[0]),     64'h1);
         end
      end
      ch_enable = 2'b00;
      in_stall  = 2'b00;
      for (int e = 25; e <= 44; e++) tick();
      chk("col_pre", 64'(flush), 64'h0);

      flush_req    = 1'b1;
      flush_req_ch = 3'd0;
      flush_req_id = 8'h05;
      tick();
      chk("col_flush", 64'(flush),      64'h1);
      chk("col_id",    64'(flush_id),   64'h0005);
      chk("col_busy",  64'(flush_busy), 64'h1);
      flush_req = 1'b0;
      tick();
      chk("defer_flush", 64'(flush),      64'h1);
      chk("defer_id",    64'(flush_id),   64'h0016);
      chk("defer_busy",  64'(flush_busy), 64'h0);
      tick();
      chk("defer_end",      64'(flush),      64'h0);
      chk("defer_end_busy", 64'(flush_busy), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
